// File: rtl/cacheline_arbiter.sv
// cacheline_arbiter: shares the single physical-memory port between the
// I-cache and the D-cache. One requester is granted at a time. Its request is
// latched and held on pmem_* until memory responds, and the response is routed
// back to it. Round-robin on ties keeps either pipeline stage from starving.
//
// Handshake: a requester raises *_read/*_write and holds it until its one-cycle
// *_resp pulse. Memory sees a strobe held from the registered grant until the
// cycle pmem_resp is high. The strobe drops on the next edge.
module cacheline_arbiter #(
    parameter int LINE_W = 256,
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t            state;
    state_t            state_next;
    logic              last_d;
    logic              last_d_next;
    logic [ADDR_W-1:0] hold_addr;
    logic [LINE_W-1:0] hold_wdata;
    logic              hold_write;
    logic              grant_i;
    logic              grant_d;

    // Requests are only considered in IDLE. On a tie, the cache not served last wins.
    always_comb begin
        grant_i = 1'b0;
        grant_d = 1'b0;
        if (state == IDLE) begin
            if (i_read && (d_read || d_write)) begin
                grant_d = !last_d;
                grant_i = last_d;
            end else begin
                grant_i = i_read;
                grant_d = d_read || d_write;
            end
        end
    end

    // Next-state logic. last_d is updated when a grant completes.
    always_comb begin
        state_next  = state;
        last_d_next = last_d;
        case (state)
            IDLE: begin
                if (grant_d)      state_next = SERVE_D;
                else if (grant_i) state_next = SERVE_I;
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    state_next  = RELEASE;
                    last_d_next = 1'b0;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    state_next  = RELEASE;
                    last_d_next = 1'b1;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State and round-robin flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_next;
            last_d <= last_d_next;
        end
    end

    // Holding registers capture the granted request. Later requester changes are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_addr  <= '0;
            hold_wdata <= '0;
            hold_write <= 1'b0;
        end else if (grant_d) begin
            hold_addr  <= d_address;
            hold_wdata <= d_wdata;
            hold_write <= d_write;
        end else if (grant_i) begin
            hold_addr  <= i_address;
            hold_wdata <= '0;
            hold_write <= 1'b0;
        end
    end

    // Memory side is driven purely from registers, so requester inputs have no combinational path to pmem_*.
    always_comb begin
        pmem_read    = (state == SERVE_I) || ((state == SERVE_D) && !hold_write);
        pmem_write   = (state == SERVE_D) && hold_write;
        pmem_address = hold_addr;
        pmem_wdata   = hold_wdata;
    end

    // Response routing: pass through to the granted cache only, with zeroed data otherwise.
    always_comb begin
        i_resp  = (state == SERVE_I) && pmem_resp;
        d_resp  = (state == SERVE_D) && pmem_resp;
        i_rdata = i_resp ? pmem_rdata : '0;
        d_rdata = d_resp ? pmem_rdata : '0;
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb_cacheline_arbiter: directed stimulus against a transaction-level model of
// the arbiter. The model tracks the current owner and the release gap, and it
// is checked on every falling edge. Tasks add hand-computed literal checks.
module tb_cacheline_arbiter;
    localparam int LINE_W = 256;
    localparam int ADDR_W = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    cacheline_arbiter #(.LINE_W(LINE_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    // clock
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    // owner: 0 = nobody, 1 = I-cache, 2 = D-cache. gap: the dead cycle after a completion.
    int                m_owner = 0;
    bit                m_gap = 0;
    bit                m_last_was_d = 0;
    bit                m_write = 0;
    logic [ADDR_W-1:0] m_addr = '0;
    logic [LINE_W-1:0] m_wdata = '0;
    int                grants_d[$];   // order of grants, 1 = D, 0 = I

    always @(negedge clk) begin
        bit want_i;
        bit want_d;
        if (rst) begin
            chk("rst_pmem_read", pmem_read, 0);
            chk("rst_pmem_write", pmem_write, 0);
            chk("rst_i_resp", i_resp, 0);
            chk("rst_d_resp", d_resp, 0);
            chk("rst_pmem_address", pmem_address, 0);
            m_owner = 0; m_gap = 0; m_last_was_d = 0; m_write = 0; m_addr = '0; m_wdata = '0;
        end else begin
            chk("m_pmem_read", pmem_read, (m_owner == 1) || (m_owner == 2 && !m_write));
            chk("m_pmem_write", pmem_write, m_owner == 2 && m_write);
            chk("m_pmem_address", pmem_address, m_addr);
            if (m_owner == 2 && m_write) chk("m_pmem_wdata", pmem_wdata, m_wdata);
            chk("m_i_resp", i_resp, m_owner == 1 && pmem_resp);
            chk("m_d_resp", d_resp, m_owner == 2 && pmem_resp);
            chk("m_i_rdata", i_rdata, (m_owner == 1 && pmem_resp) ? pmem_rdata : '0);
            chk("m_d_rdata", d_rdata, (m_owner == 2 && pmem_resp) ? pmem_rdata : '0);
            // advance to the next cycle using inputs that the coming edge will sample
            if (m_owner != 0) begin
                if (pmem_resp) begin
                    m_last_was_d = (m_owner == 2);
                    m_owner = 0;
                    m_gap = 1;
                end
            end else if (m_gap) begin
                m_gap = 0;
            end else begin
                want_i = i_read;
                want_d = d_read || d_write;
                if (want_d && (!want_i || !m_last_was_d)) begin
                    m_owner = 2; m_write = d_write; m_addr = d_address; m_wdata = d_wdata;
                    grants_d.push_back(1);
                end else if (want_i) begin
                    m_owner = 1; m_write = 0; m_addr = i_address; m_wdata = '0;
                    grants_d.push_back(0);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait for a strobe, check it, answer after lat cycles with data, and check the routed response.
    // n returns the number of falling edges spent waiting for the strobe.
    task automatic serve(input int lat, input logic [LINE_W-1:0] data, input bit exp_wr,
                         input logic [ADDR_W-1:0] exp_addr, input bit exp_d, output int n);
        n = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("strobe_timeout", n < 20, 1);
        chk("lit_pmem_write", pmem_write, exp_wr);
        chk("lit_pmem_read", pmem_read, !exp_wr);
        chk("lit_pmem_address", pmem_address, exp_addr);
        repeat (lat) @(posedge clk);
        #1;
        pmem_resp = 1'b1;
        pmem_rdata = data;
        @(negedge clk);
        chk("lit_i_resp", i_resp, !exp_d);
        chk("lit_d_resp", d_resp, exp_d);
        chk("lit_rdata", exp_d ? d_rdata : i_rdata, data);
        tick();
        pmem_resp = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        chk("lit_release_no_strobe", pmem_read | pmem_write, 0);
        chk("lit_release_no_resp", i_resp | d_resp, 0);
        tick();
    endtask

    initial begin
        int n;
        // reset
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pmem_read", pmem_read, 0);
        chk("reset_i_rdata", i_rdata, 0);
        rst = 1'b0;
        tick();

        // lone I fill: strobe one cycle after the request, resp 3 cycles after strobe
        i_read = 1'b1; i_address = 32'h0000_0040;
        serve(3, {32{8'hA5}}, 0, 32'h40, 0, n);
        chk("lone_i_latency", n, 1);
        i_read = 1'b0;
        tick();

        // D writeback
        d_write = 1'b1; d_address = 32'h8000_0100; d_wdata = {8{32'h1234_5678}};
        serve(2, '0, 1, 32'h8000_0100, 1, n);
        chk("wb_wdata_model_pin", m_wdata, {8{32'h1234_5678}});
        d_write = 1'b0;
        tick();

        // reset again so the tie test starts from last_d = 0
        rst = 1'b1; tick(); rst = 1'b0; tick();
        grants_d.delete();
        i_read = 1'b1; i_address = 32'h0000_1000;
        d_read = 1'b1; d_address = 32'h0000_2000;
        serve(1, {64{4'h1}}, 0, 32'h2000, 1, n);
        serve(2, {64{4'h2}}, 0, 32'h1000, 0, n);
        serve(1, {64{4'h3}}, 0, 32'h2000, 1, n);
        i_read = 1'b0; d_read = 1'b0;
        tick();
        chk("tie_grant_count", grants_d.size(), 3);
        if (grants_d.size() == 3) begin
            chk("tie_order_0", grants_d[0], 1);
            chk("tie_order_1", grants_d[1], 0);
            chk("tie_order_2", grants_d[2], 1);
        end

        // input change mid-grant: the latched address holds
        i_read = 1'b1; i_address = 32'h0000_0080;
        tick(); tick();
        i_address = 32'hDEAD_0000;
        @(negedge clk);
        chk("midgrant_addr", pmem_address, 32'h80);
        serve(2, {32{8'h5A}}, 0, 32'h80, 0, n);
        i_read = 1'b0;
        tick();

        // reset mid-transaction with a response arriving in the same cycle
        d_write = 1'b1; d_address = 32'h0000_0200; d_wdata = {LINE_W{1'b1}};
        tick(); tick();
        @(negedge clk);
        chk("pre_reset_write", pmem_write, 1);
        @(posedge clk); #1;
        rst = 1'b1; pmem_resp = 1'b1;
        #1;
        chk("async_rst_write", pmem_write, 0);
        chk("async_rst_read", pmem_read, 0);
        chk("async_rst_d_resp", d_resp, 0);
        d_write = 1'b0;
        tick();
        pmem_resp = 1'b0; rst = 1'b0;
        tick();
        i_read = 1'b1; i_address = 32'h0000_0300;
        d_read = 1'b1; d_address = 32'h0000_0400;
        serve(1, {64{4'h7}}, 0, 32'h400, 1, n);
        d_read = 1'b0;
        serve(1, {64{4'h8}}, 0, 32'h300, 0, n);
        i_read = 1'b0;
        tick();

        // illegal D request: write wins
        d_read = 1'b1; d_write = 1'b1; d_address = 32'h0000_0500; d_wdata = {16{16'hBEEF}};
        serve(1, '0, 1, 32'h500, 1, n);
        d_read = 1'b0; d_write = 1'b0;
        tick(); tick();

        // stray pmem_resp in IDLE
        pmem_resp = 1'b1; pmem_rdata = {LINE_W{1'b1}};
        @(negedge clk);
        chk("stray_i_resp", i_resp, 0);
        chk("stray_d_resp", d_resp, 0);
        chk("stray_d_rdata", d_rdata, 0);
        tick();
        pmem_resp = 1'b0; pmem_rdata = '0;
        repeat (3) tick();
        chk("stray_no_strobe", pmem_read | pmem_write, 0);

        // random back-to-back I fills with model checking only
        for (int k = 0; k < 4; k++) begin
            i_read = 1'b1; i_address = $urandom_range(255, 0) << 5;
            serve($urandom_range(3, 0), {8{$urandom}}, 0, i_address, 0, n);
            i_read = 1'b0;
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end
endmodule
